count_monitor: RTL

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_mon_pkg.sv | 18 +
 rtl/count_monitor_sat_counter.sv | 32 +++
 rtl/count_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and constants for the count_monitor block.
package count_mon_pkg;

  // Monitor tracking state.
  typedef enum logic [1:0] {
    StUnlocked,
    StSync,
    StLocked
  } mon_state_e;

  // Statistics counter widths.
  localparam int unsigned WrapCountW = 16;
  localparam int unsigned ErrCountW  = 8;

  // Width of the consecutive-legal-step counter (LOCK_LEN tops out at 15).
  localparam int unsigned MatchW = 4;

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: increment on request, hold once all-ones is reached.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/count_monitor.sv
// Monitors a free-running mod-N counter, locks after LOCK_LEN legal steps and
// flags errors, wraps and upstream restarts as registered one-cycle pulses.
// Optional statistics counters are built only when COUNT_MON_STATS_EN is defined;
// otherwise wrap_count and err_count read 0.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned N        = 10,
  parameter int unsigned LOCK_LEN = 3,
  localparam int unsigned W       = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          q,
  input  logic                  cnt_en,
  output logic                  locked,
  output logic                  err,
  output logic                  wrap,
  output logic                  restart,
  output logic [WrapCountW-1:0] wrap_count,
  output logic [ErrCountW-1:0]  err_count
);

  localparam logic [W:0]        NExt    = (W + 1)'(N);
  localparam logic [W-1:0]      QMax    = W'(N - 1);
  localparam logic [MatchW-1:0] LockCnt = MatchW'(LOCK_LEN);

  mon_state_e        state_q, state_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [W-1:0]      q_prev_q;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              wrap_q, wrap_d;
  logic              restart_q, restart_d;

  logic              in_range;
  logic              step_ok;
  logic              is_wrap;
  logic              is_restart;
  logic [W-1:0]      q_next;
  logic [MatchW-1:0] match_inc;

  // Step classification of the current sample against the previous one.
  always_comb begin
    in_range   = ({1'b0, q} < NExt);
    q_next     = (q_prev_q == QMax) ? '0 : q_prev_q + W'(1);
    step_ok    = cnt_en ? (q == q_next) : (q == q_prev_q);
    is_wrap    = cnt_en && (q_prev_q == QMax) && (q == '0);
    // A jump to 0 from mid-count is an upstream reset, not a fault.
    is_restart = (q == '0) && (q_prev_q != QMax) && (q_prev_q != '0);
    match_inc  = match_q + MatchW'(1);
  end

  // Next-state and pulse decode.
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    err_d     = 1'b0;
    wrap_d    = 1'b0;
    restart_d = 1'b0;
    case (state_q)
      StUnlocked: begin
        if (!in_range) begin
          err_d = 1'b1;
        end else begin
          state_d = StSync;
          match_d = '0;
        end
      end
      StSync: begin
        if (!in_range) begin
          err_d   = 1'b1;
          state_d = StUnlocked;
          match_d = '0;
        end else if (step_ok) begin
          wrap_d = is_wrap;
          if (match_inc == LockCnt) begin
            state_d = StLocked;
            match_d = '0;
          end else begin
            match_d = match_inc;
          end
        end else begin
          // Mismatches while synchronising are silent.
          match_d = '0;
        end
      end
      StLocked: begin
        if (!in_range) begin
          err_d   = 1'b1;
          state_d = StUnlocked;
          match_d = '0;
        end else if (is_restart) begin
          restart_d = 1'b1;
        end else if (step_ok) begin
          wrap_d = is_wrap;
        end else begin
          err_d   = 1'b1;
          state_d = StSync;
          match_d = '0;
        end
      end
      default: begin
        state_d = StUnlocked;
        match_d = '0;
      end
    endcase
    locked_d = (state_d == StLocked);
  end

  // State, sample history and registered outputs; reset suppresses any pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StUnlocked;
      match_q   <= '0;
      q_prev_q  <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      q_prev_q  <= q;
      locked_q  <= locked_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      restart_q <= restart_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign wrap    = wrap_q;
  assign restart = restart_q;

`ifdef COUNT_MON_STATS_EN
  // Counters advance on the same edge that registers their pulse.
  sat_counter #(
    .Width(WrapCountW)
  ) u_wrap_count (
    .clk_i  (clk),
    .reset_i(reset),
    .inc_i  (wrap_d),
    .count_o(wrap_count)
  );

  sat_counter #(
    .Width(ErrCountW)
  ) u_err_count (
    .clk_i  (clk),
    .reset_i(reset),
    .inc_i  (err_d),
    .count_o(err_count)
  );
`else
  assign wrap_count = '0;
  assign err_count  = '0;
`endif

endmodule
